video2ram: RTL and testbench
============================

VIDEO2RAM -- requirements
Module: video2ram

Interface
REQ-001 Parameter H_CAPTURE_START, default 0, first captured pixel index within a line.
REQ-002 Parameter H_CAPTURE_END, default 640, first non-captured pixel index (exclusive).
REQ-003 Parameter V_CAPTURE_START, default 0, first captured line index within a frame.
REQ-004 Parameter V_CAPTURE_END, default 480, first non-captured line index (exclusive).
REQ-005 Parameter BUFFER_LINE_LENGTH, default 640, words per buffer line.
REQ-006 Parameter RAM_NUMWORDS, default 23040, buffer size in words (36 lines).
REQ-007 Parameter TRIGGER_LINE, default 8, line index at which starttrigger fires.
REQ-008 Parameter LINES_240P_MAX, default 300, frame line count below which input is 240p.
REQ-009 clock  in  1  single clock; all logic on its rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 pixel_en  in  1  input pixel qualifier; all video inputs sampled only when high.
REQ-012 data_in  in  24  RGB888 pixel, R in [23:16].
REQ-013 hsync_in  in  1  horizontal sync, active-low.
REQ-014 vsync_in  in  1  vertical sync, active-low.
REQ-015 wraddr  out  15  line-buffer write address.
REQ-016 wrdata  out  24  line-buffer write data.
REQ-017 wren  out  1  line-buffer write enable.
REQ-018 starttrigger  out  1  one-cycle pulse telling the reader to start output.
REQ-019 line_doubler  out  1  high when measured input is 240p.
REQ-020 locked  out  1  high while state is CAPTURE.

Function
REQ-021 Sync edges: hsync_fall/vsync_fall SHALL be detected as a 1->0 change between consecutive pixel_en-qualified samples.
REQ-022 counterX (12 bit): 0 on hsync_fall, else +1 per pixel_en, saturating at 4095.
REQ-023 counterY (12 bit): 0 on vsync_fall, else +1 per hsync_fall, saturating at 4095; vsync_fall wins on a simultaneous edge.
REQ-024 States IDLE, ARMED, CAPTURE; IDLE->ARMED on vsync_fall; ARMED->CAPTURE on next vsync_fall.
REQ-025 CAPTURE->ARMED on vsync_fall when measured line_doubler differs from the current value.
REQ-026 ARMED or CAPTURE->IDLE when counterX reaches 4095 (hsync lost); wren deasserts in that same cycle.
REQ-027 frame_lines = counterY value at vsync_fall; line_doubler updated at every vsync_fall to (frame_lines < LINES_240P_MAX).
REQ-028 A pixel is written when state==CAPTURE, pixel_en=1, H_CAPTURE_START<=counterX<H_CAPTURE_END, V_CAPTURE_START<=counterY<V_CAPTURE_END.
REQ-029 wren, wrdata, wraddr SHALL be registered, one cycle after the qualifying sample; wren is low in every other cycle.
REQ-030 wraddr = ramY + ramX; ramX +1 per written pixel, 0 on hsync_fall.
REQ-031 On hsync_fall ending a captured line: ramY += BUFFER_LINE_LENGTH, or 0 if ramY + BUFFER_LINE_LENGTH >= RAM_NUMWORDS (wrap).
REQ-032 ramY = 0 on vsync_fall and on entry to CAPTURE.
REQ-033 starttrigger pulses for exactly one cycle, in CAPTURE only, in the cycle after the hsync_fall that makes counterY == TRIGGER_LINE; it fires once per frame.
REQ-034 Sync sample state, counters and addresses hold while pixel_en=0.

Reset
REQ-035 When reset is low: state IDLE; counters, ramX, ramY, wraddr, wrdata, wren, starttrigger, line_doubler and locked all 0; sync sample registers 1.
REQ-036 Reset asserted mid-line SHALL stop writes immediately; after release, no write occurs before two vsync_fall edges.

Structure
REQ-037 The state enum and parameter defaults SHALL live in a shared package, dc_capture_pkg.
REQ-038 Sync edge detection SHALL be one sub-module, sync_edge_detect, instantiated for hsync_in and vsync_in.

Verification
REQ-039 Reset, two 525-line frames of 858 pixels, pixel_en always high -> third frame line 0 writes wraddr 0..639, line 1 writes 640..1279, line_doubler=0.
REQ-040 480 captured lines -> line 36 wraps to wraddr 0, and no wraddr >= 23040 ever appears.
REQ-041 Switch to 263-line frames -> line_doubler=1 after the first short frame, state ARMED, no writes for one frame, then CAPTURE again.
REQ-042 Hold hsync_in high for 4095 qualified pixels in CAPTURE -> state IDLE, locked=0, wren=0 from that cycle.
REQ-043 Hsync and vsync fall on the same sample -> counterY=0, ramY=0, and one starttrigger pulse after line 8.
REQ-044 pixel_en toggling 1/0 -> wraddr sequence identical to the always-high case; reset at pixel 300 -> wren low immediately.

Source files
------------

// File: rtl/dc_capture_pkg.sv
// Shared capture-state encoding, counter limits and default window geometry.
// Pure definitions: no latency and no flow control of its own.
package dc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

    localparam int CNT_W   = 12;
    localparam int ADDR_W  = 15;
    localparam int PIXEL_W = 24;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int H_CAPTURE_START_DEF    = 0;
    localparam int H_CAPTURE_END_DEF      = 640;
    localparam int V_CAPTURE_START_DEF    = 0;
    localparam int V_CAPTURE_END_DEF      = 480;
    localparam int BUFFER_LINE_LENGTH_DEF = 640;
    localparam int RAM_NUMWORDS_DEF       = 23040;
    localparam int TRIGGER_LINE_DEF       = 8;
    localparam int LINES_240P_MAX_DEF     = 300;

endpackage

// File: rtl/sync_edge_detect.sv
// Flags a 1->0 change of a sync input between consecutive qualified samples.
// Latency: fall_o is combinational in the sampling cycle; no backpressure, en_i only qualifies.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic sig_i,
    output logic fall_o
);

    logic sample_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_q <= 1'b1;
        end else if (en_i) begin
            sample_q <= sig_i;
        end
    end

    assign fall_o = en_i & sample_q & ~sig_i;

endmodule

// File: rtl/video2ram.sv
// video2ram: captures a window of each input frame into a wrapping line buffer.
// Latency: write one cycle after the qualifying pixel; no backpressure, pixel_en only qualifies input.
module video2ram
    import dc_capture_pkg::*;
#(
    parameter int H_CAPTURE_START    = H_CAPTURE_START_DEF,
    parameter int H_CAPTURE_END      = H_CAPTURE_END_DEF,
    parameter int V_CAPTURE_START    = V_CAPTURE_START_DEF,
    parameter int V_CAPTURE_END      = V_CAPTURE_END_DEF,
    parameter int BUFFER_LINE_LENGTH = BUFFER_LINE_LENGTH_DEF,
    parameter int RAM_NUMWORDS       = RAM_NUMWORDS_DEF,
    parameter int TRIGGER_LINE       = TRIGGER_LINE_DEF,
    parameter int LINES_240P_MAX     = LINES_240P_MAX_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pixel_en,
    input  logic [PIXEL_W-1:0] data_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [ADDR_W-1:0]  wraddr,
    output logic [PIXEL_W-1:0] wrdata,
    output logic               wren,
    output logic               starttrigger,
    output logic               line_doubler,
    output logic               locked
);

    cap_state_e         state_q, state_d;
    logic [CNT_W-1:0]   counter_x_q, counter_x_d;
    logic [CNT_W-1:0]   counter_y_q, counter_y_d;
    logic [ADDR_W-1:0]  ram_x_q, ram_x_d;
    logic [ADDR_W-1:0]  ram_y_q, ram_y_d;
    logic [ADDR_W-1:0]  wraddr_q, wraddr_d;
    logic [PIXEL_W-1:0] wrdata_q, wrdata_d;
    logic               wren_q, wren_d;
    logic               trig_q, trig_d;
    logic               trig_done_q, trig_done_d;
    logic               dbl_q, dbl_d;

    logic hsync_fall, vsync_fall;
    logic hsync_lost, dbl_meas, x_in, y_in, wr_qual, fire;

    sync_edge_detect u_hsync_edge (
        .clock  (clock),
        .reset  (reset),
        .en_i   (pixel_en),
        .sig_i  (hsync_in),
        .fall_o (hsync_fall)
    );

    sync_edge_detect u_vsync_edge (
        .clock  (clock),
        .reset  (reset),
        .en_i   (pixel_en),
        .sig_i  (vsync_in),
        .fall_o (vsync_fall)
    );

    always_comb begin
        state_d     = state_q;
        counter_x_d = counter_x_q;
        counter_y_d = counter_y_q;
        ram_x_d     = ram_x_q;
        ram_y_d     = ram_y_q;
        wraddr_d    = wraddr_q;
        wrdata_d    = wrdata_q;
        dbl_d       = dbl_q;

        // A line that never ends means the sync source is gone.
        hsync_lost = (counter_x_q == CNT_MAX);
        dbl_meas   = (int'(counter_y_q) < LINES_240P_MAX);
        x_in       = (int'(counter_x_q) >= H_CAPTURE_START) && (int'(counter_x_q) < H_CAPTURE_END);
        y_in       = (int'(counter_y_q) >= V_CAPTURE_START) && (int'(counter_y_q) < V_CAPTURE_END);
        wr_qual    = (state_q == ST_CAPTURE) && pixel_en && !hsync_lost && x_in && y_in;

        if (pixel_en) begin
            if (hsync_fall) begin
                counter_x_d = '0;
            end else if (counter_x_q != CNT_MAX) begin
                counter_x_d = counter_x_q + 1'b1;
            end
            if (vsync_fall) begin
                counter_y_d = '0;
            end else if (hsync_fall && counter_y_q != CNT_MAX) begin
                counter_y_d = counter_y_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (vsync_fall) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (hsync_lost)      state_d = ST_IDLE;
                else if (vsync_fall) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (hsync_lost)                           state_d = ST_IDLE;
                else if (vsync_fall && dbl_meas != dbl_q) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase

        if (vsync_fall) dbl_d = dbl_meas;

        if (hsync_fall) begin
            ram_x_d = '0;
        end else if (wr_qual) begin
            ram_x_d = ram_x_q + 1'b1;
        end

        if (vsync_fall || (state_q != ST_CAPTURE && state_d == ST_CAPTURE)) begin
            ram_y_d = '0;
        end else if (hsync_fall && state_q == ST_CAPTURE && y_in) begin
            if (int'(ram_y_q) + BUFFER_LINE_LENGTH >= RAM_NUMWORDS) ram_y_d = '0;
            else ram_y_d = ram_y_q + ADDR_W'(BUFFER_LINE_LENGTH);
        end

        wren_d = wr_qual;
        if (wr_qual) begin
            wraddr_d = ram_y_q + ram_x_q;
            wrdata_d = data_in;
        end

        // trig_done blocks a second pulse if counterY ever revisits the line.
        fire        = (state_q == ST_CAPTURE) && hsync_fall && !(trig_done_q && !vsync_fall)
                      && (int'(counter_y_d) == TRIGGER_LINE);
        trig_d      = fire;
        trig_done_d = vsync_fall ? fire : (trig_done_q | fire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            counter_x_q <= '0;
            counter_y_q <= '0;
            ram_x_q     <= '0;
            ram_y_q     <= '0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            wren_q      <= 1'b0;
            trig_q      <= 1'b0;
            trig_done_q <= 1'b0;
            dbl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_x_q <= counter_x_d;
            counter_y_q <= counter_y_d;
            ram_x_q     <= ram_x_d;
            ram_y_q     <= ram_y_d;
            wraddr_q    <= wraddr_d;
            wrdata_q    <= wrdata_d;
            wren_q      <= wren_d;
            trig_q      <= trig_d;
            trig_done_q <= trig_done_d;
            dbl_q       <= dbl_d;
        end
    end

    assign wraddr       = wraddr_q;
    assign wrdata       = wrdata_q;
    assign wren         = wren_q;
    assign starttrigger = trig_q;
    assign line_doubler = dbl_q;
    assign locked       = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_video2ram.sv
// Drives scaled-down frames with random pixel_en gaps and random pixel data.
// Expected writes, triggers and lock status come from a frame-geometry model.
module tb_video2ram;

    localparam int W     = 40;
    localparam int HS    = 2;
    localparam int HE    = 18;
    localparam int VS    = 1;
    localparam int VE    = 25;
    localparam int BLL   = 16;
    localparam int RAM   = 96;
    localparam int TRIG  = 8;
    localparam int LMAX  = 22;
    localparam int LONG  = 30;
    localparam int SHORT = 16;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        pixel_en = 1'b0;
    logic [23:0] data_in  = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [14:0] wraddr;
    logic [23:0] wrdata;
    logic        wren;
    logic        starttrigger;
    logic        line_doubler;
    logic        locked;

    always #5 clock = ~clock;

    video2ram #(
        .H_CAPTURE_START    (HS),
        .H_CAPTURE_END      (HE),
        .V_CAPTURE_START    (VS),
        .V_CAPTURE_END      (VE),
        .BUFFER_LINE_LENGTH (BLL),
        .RAM_NUMWORDS       (RAM),
        .TRIGGER_LINE       (TRIG),
        .LINES_240P_MAX     (LMAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_en     (pixel_en),
        .data_in      (data_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .wraddr       (wraddr),
        .wrdata       (wrdata),
        .wren         (wren),
        .starttrigger (starttrigger),
        .line_doubler (line_doubler),
        .locked       (locked)
    );

    typedef struct packed {
        logic [14:0] addr;
        logic [23:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors     = 0;
    int  checks     = 0;
    int  wr_total   = 0;
    int  trig_total = 0;
    int  trig_wr    = 0;
    int  max_addr   = 0;
    int  density    = 100;
    // Frame-level model: 0 idle, 1 armed, 2 capturing.
    int  m_state    = 0;
    int  m_dbl      = 0;
    int  m_ycount   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (wren === 1'b1) begin
                if (wr_total < exp_q.size()) begin
                    check_val("wraddr", 32'(wraddr), 32'(exp_q[wr_total].addr));
                    check_val("wrdata", 32'(wrdata), 32'(exp_q[wr_total].data));
                end else begin
                    check_val("spurious_wren", 32'(wren), 32'd0);
                end
                if (int'(wraddr) > max_addr) max_addr = int'(wraddr);
                wr_total++;
            end
            if (starttrigger === 1'b1) begin
                trig_total++;
                trig_wr = wr_total;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        pixel_en = 1'b0;
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        data_in  = 24'($urandom);
    endtask

    task automatic sample(input logic hs, input logic vs, input logic [23:0] d);
        while (int'($urandom % 100) >= density) idle_cycle();
        @(posedge clock);
        #1;
        pixel_en = 1'b1;
        hsync_in = hs;
        vsync_in = vs;
        data_in  = d;
    endtask

    task automatic apply_reset_mid();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        pixel_en = 1'b0;
        #1;
        check_val("midrst_wren", 32'(wren), 32'd0);
        check_val("midrst_locked", 32'(locked), 32'd0);
        while (exp_q.size() > wr_total) void'(exp_q.pop_back());
        m_state  = 0;
        m_dbl    = 0;
        m_ycount = 0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic drive_frame(input int lines, input int rst_line);
        int          wr0, exp0, trig0, exp_trig, new_dbl;
        logic [23:0] d;
        wr_t         e;
        wr0      = wr_total;
        exp0     = exp_q.size();
        trig0    = trig_total;
        exp_trig = 0;
        for (int y = 0; y < lines; y++) begin
            for (int p = 0; p < W; p++) begin
                if (y == rst_line && p == HS + 8) apply_reset_mid();
                if (y == 1 && p == 0) begin
                    check_val("line_doubler", 32'(line_doubler), 32'(m_dbl));
                    check_val("locked", 32'(locked), 32'(m_state == 2));
                end
                if (p == 0) begin
                    if (y == 0) begin
                        new_dbl = (m_ycount < LMAX) ? 1 : 0;
                        case (m_state)
                            0:       m_state = 1;
                            1:       m_state = 2;
                            default: if (new_dbl != m_dbl) m_state = 1;
                        endcase
                        m_dbl    = new_dbl;
                        m_ycount = 0;
                    end else begin
                        m_ycount++;
                    end
                    if (y == TRIG && m_state == 2) exp_trig = 1;
                end
                d = 24'($urandom);
                if (m_state == 2 && p >= HS + 1 && p < HE + 1 && y >= VS && y < VE) begin
                    e.addr = 15'(((y - VS) % (RAM / BLL)) * BLL + (p - 1 - HS));
                    e.data = d;
                    exp_q.push_back(e);
                end
                sample(p >= 4, y >= 3, d);
            end
        end
        repeat (3) idle_cycle();
        check_val("frame_writes", 32'(wr_total - wr0), 32'(exp_q.size() - exp0));
        check_val("frame_trig", 32'(trig_total - trig0), 32'(exp_trig));
        if (exp_trig == 1 && trig_total - trig0 == 1)
            check_val("trig_pos", 32'(trig_wr - wr0), 32'((TRIG - VS) * (HE - HS)));
    endtask

    task automatic lose_hsync();
        for (int n = 0; n < 4200; n++) begin
            if (n == 3900) check_val("lock_before_loss", 32'(locked), 32'(m_state == 2));
            sample(1'b1, 1'b1, 24'($urandom));
        end
        repeat (2) idle_cycle();
        m_state = 0;
        check_val("lock_after_loss", 32'(locked), 32'(m_state == 2));
        check_val("wren_after_loss", 32'(wren), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        #1 reset = 1'b0;
        #12;
        check_val("rst_wren", 32'(wren), 32'd0);
        check_val("rst_wraddr", 32'(wraddr), 32'd0);
        check_val("rst_wrdata", 32'(wrdata), 32'd0);
        check_val("rst_trigger", 32'(starttrigger), 32'd0);
        check_val("rst_doubler", 32'(line_doubler), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        density = 100;
        repeat (3) drive_frame(LONG, -1);
        density = 50 + int'($urandom_range(0, 40));
        repeat (3) drive_frame(SHORT, -1);
        repeat (3) drive_frame(LONG, -1);
        lose_hsync();
        repeat (2) drive_frame(LONG, -1);
        drive_frame(LONG, 5);
        repeat (2) drive_frame(LONG, -1);

        check_val("max_wraddr", 32'(max_addr), 32'(RAM - 1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
